// File: rtl/id_ex_register.sv
// ID/EX pipeline register. Stall or flush squashes the control set while
// still forwarding the data set, and stall-induced bubbles are counted.
module id_ex_register #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 count_clr,
  input  logic                 id_valid,
  input  logic [31:0]          id_pc_plus4,
  input  logic [31:0]          id_read_data1,
  input  logic [31:0]          id_read_data2,
  input  logic [31:0]          id_sign_ext,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic [4:0]           id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_memtoreg,
  input  logic                 id_memread,
  input  logic                 id_memwrite,
  input  logic                 id_branch,
  input  logic                 id_regdst,
  input  logic                 id_alusrc,
  input  logic [1:0]           id_aluop,
  output logic                 ex_valid,
  output logic [31:0]          ex_pc_plus4,
  output logic [31:0]          ex_read_data1,
  output logic [31:0]          ex_read_data2,
  output logic [31:0]          ex_sign_ext,
  output logic [4:0]           ex_rs,
  output logic [4:0]           ex_rt,
  output logic [4:0]           ex_rd,
  output logic                 ex_regwrite,
  output logic                 ex_memtoreg,
  output logic                 ex_memread,
  output logic                 ex_memwrite,
  output logic                 ex_branch,
  output logic                 ex_regdst,
  output logic                 ex_alusrc,
  output logic [1:0]           ex_aluop,
  output logic [CNT_WIDTH-1:0] bubble_count
);

  logic load_ctrl;
  logic count_bubble;
  logic count_full;

  // Only a normal cycle carrying a real instruction may pass control through.
  assign load_ctrl    = id_valid & ~flush & ~stall;
  assign count_bubble = stall & ~flush;
  assign count_full   = &bubble_count;

  // Register specifiers and operands pass even in a bubble so forwarding
  // comparisons in EX still see the squashed instruction's fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc_plus4   <= '0;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_sign_ext   <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
    end else begin
      ex_pc_plus4   <= id_pc_plus4;
      ex_read_data1 <= id_read_data1;
      ex_read_data2 <= id_read_data2;
      ex_sign_ext   <= id_sign_ext;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_aluop    <= 2'b00;
    end else if (load_ctrl) begin
      ex_valid    <= 1'b1;
      ex_regwrite <= id_regwrite;
      ex_memtoreg <= id_memtoreg;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_branch   <= id_branch;
      ex_regdst   <= id_regdst;
      ex_alusrc   <= id_alusrc;
      ex_aluop    <= id_aluop;
    end else begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_aluop    <= 2'b00;
    end
  end

  // Clear wins over a same-edge increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (count_clr) begin
      bubble_count <= '0;
    end else if (count_bubble && !count_full) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: randomized traffic against a
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_id_ex_register;

  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } data_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic count_clr = 1'b0;
  logic id_valid = 1'b0;
  ctrl_t in_ctrl = '0;
  data_t in_data = '0;

  logic ex_valid;
  logic [31:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_sign_ext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite;
  logic ex_branch, ex_regdst, ex_alusrc;
  logic [1:0] ex_aluop;
  logic [CNT_WIDTH-1:0] bubble_count;

  ctrl_t dut_ctrl;
  data_t dut_data;
  assign dut_ctrl = {ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite,
                     ex_branch, ex_regdst, ex_alusrc, ex_aluop};
  assign dut_data = {ex_pc_plus4, ex_read_data1, ex_read_data2, ex_sign_ext,
                     ex_rs, ex_rt, ex_rd};

  int checks = 0;
  int errors = 0;

  ctrl_t m_ctrl;
  data_t m_data;
  logic  m_valid;
  int    m_count;

  id_ex_register #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .count_clr    (count_clr),
    .id_valid     (id_valid),
    .id_pc_plus4  (in_data.pc4),
    .id_read_data1(in_data.rd1),
    .id_read_data2(in_data.rd2),
    .id_sign_ext  (in_data.sext),
    .id_rs        (in_data.rs),
    .id_rt        (in_data.rt),
    .id_rd        (in_data.rd),
    .id_regwrite  (in_ctrl.regwrite),
    .id_memtoreg  (in_ctrl.memtoreg),
    .id_memread   (in_ctrl.memread),
    .id_memwrite  (in_ctrl.memwrite),
    .id_branch    (in_ctrl.branch),
    .id_regdst    (in_ctrl.regdst),
    .id_alusrc    (in_ctrl.alusrc),
    .id_aluop     (in_ctrl.aluop),
    .ex_valid     (ex_valid),
    .ex_pc_plus4  (ex_pc_plus4),
    .ex_read_data1(ex_read_data1),
    .ex_read_data2(ex_read_data2),
    .ex_sign_ext  (ex_sign_ext),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memtoreg  (ex_memtoreg),
    .ex_memread   (ex_memread),
    .ex_memwrite  (ex_memwrite),
    .ex_branch    (ex_branch),
    .ex_regdst    (ex_regdst),
    .ex_alusrc    (ex_alusrc),
    .ex_aluop     (ex_aluop),
    .bubble_count (bubble_count)
  );

  always #5 clk = ~clk;

  // Reference: an instruction reaches EX with its control only on a clean,
  // valid cycle; operands always flow; bubbles counted with a ceiling.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_count <= 0;
    end else begin
      m_data  <= in_data;
      m_valid <= id_valid && !stall && !flush;
      m_ctrl  <= (id_valid && !stall && !flush) ? in_ctrl : ctrl_t'(0);
      if (count_clr)
        m_count <= 0;
      else if (stall && !flush)
        m_count <= (m_count + 1 > CNT_MAX) ? CNT_MAX : m_count + 1;
    end
  end

  task automatic checkLiteral(input string name, input logic [159:0] actual,
                              input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput();
    checkLiteral("model_ctrl",  160'(dut_ctrl),     160'(m_ctrl));
    checkLiteral("model_data",  160'(dut_data),     160'(m_data));
    checkLiteral("model_valid", 160'(ex_valid),     160'(m_valid));
    checkLiteral("model_count", 160'(bubble_count), 160'(m_count));
  endtask

  always @(negedge clk) checkOutput();

  task automatic applyStimulus(input logic s, input logic f, input logic clr,
                               input logic v);
    @(negedge clk);
    stall     = s;
    flush     = f;
    count_clr = clr;
    id_valid  = v;
    in_ctrl   = ctrl_t'($urandom);
    in_data   = {$urandom, $urandom, $urandom, $urandom, 15'($urandom)};
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held: edges with live inputs must not capture anything.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) afterEdge();
    checkLiteral("reset_all_zero",
                 160'({dut_ctrl, dut_data, ex_valid, bubble_count}), 160'(0));

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    in_ctrl.memread = 1'b1;
    in_data.rt  = 5'd5;
    in_data.rd1 = 32'h1234_5678;
    afterEdge();
    checkLiteral("normal_memread", 160'(ex_memread),    160'(1));
    checkLiteral("normal_rt",      160'(ex_rt),         160'(5));
    checkLiteral("normal_rd1",     160'(ex_read_data1), 160'(32'h1234_5678));
    checkLiteral("normal_valid",   160'(ex_valid),      160'(1));
    checkLiteral("normal_count",   160'(bubble_count),  160'(0));

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    in_ctrl.regwrite = 1'b1;
    in_ctrl.memread  = 1'b1;
    in_data.rs       = 5'd5;
    afterEdge();
    checkLiteral("loaduse_regwrite", 160'(ex_regwrite),  160'(0));
    checkLiteral("loaduse_memread",  160'(ex_memread),   160'(0));
    checkLiteral("loaduse_valid",    160'(ex_valid),     160'(0));
    checkLiteral("loaduse_rs",       160'(ex_rs),        160'(5));
    checkLiteral("loaduse_count",    160'(bubble_count), 160'(1));

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    in_ctrl = '1;
    afterEdge();
    checkLiteral("prio_ctrl",  160'(dut_ctrl),     160'(0));
    checkLiteral("prio_valid", 160'(ex_valid),     160'(0));
    checkLiteral("prio_count", 160'(bubble_count), 160'(1));

    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    afterEdge();
    checkLiteral("sat_count",       160'(bubble_count), 160'(15));
    checkLiteral("sat_model_count", 160'(m_count),      160'(15));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    afterEdge();
    checkLiteral("clr_count", 160'(bubble_count), 160'(0));

    // Load state, then reset asynchronously in the middle of a stall cycle.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    in_ctrl.regwrite = 1'b1;
    in_data.pc4 = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkLiteral("async_reset_zero",
                 160'({dut_ctrl, dut_data, ex_valid, bubble_count}), 160'(0));
    afterEdge();
    checkLiteral("reset_no_bubble", 160'(bubble_count), 160'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    in_data.pc4 = 32'h0000_0404;
    afterEdge();
    checkLiteral("post_reset_valid", 160'(ex_valid),     160'(1));
    checkLiteral("post_reset_pc4",   160'(ex_pc_plus4),  160'(32'h0000_0404));
    checkLiteral("post_reset_count", 160'(bubble_count), 160'(0));

    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 15),
                    1'($urandom_range(0, 99) < 4),  1'($urandom_range(0, 99) < 80));
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of the bubble counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  load-use hazard from the hazard detection unit; insert bubble.
REQ-005 flush  input  1  branch/jump squash of the instruction in ID.
REQ-006 count_clr  input  1  synchronous clear of bubble_count.
REQ-007 id_valid  input  1  ID stage holds a real instruction.
REQ-008 id_pc_plus4, id_read_data1, id_read_data2, id_sign_ext  input  32 each  ID datapath values.
REQ-009 id_rs, id_rt, id_rd  input  5 each  ID register specifiers.
REQ-010 id_regwrite, id_memtoreg, id_memread, id_memwrite, id_branch, id_regdst, id_alusrc  input  1 each  ID control lines.
REQ-011 id_aluop  input  2  ID ALU operation class.
REQ-012 ex_* outputs  output  same widths as REQ-008..REQ-011  registered copies; ex_memread and ex_rt feed the hazard detection unit.
REQ-013 ex_valid  output  1  EX stage holds a real instruction.
REQ-014 bubble_count  output  CNT_WIDTH  number of bubbles inserted due to stall.

Function
REQ-015 All ex_* outputs, ex_valid and bubble_count SHALL be registered; no combinational input-to-output path.
REQ-016 Control set = ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_branch, ex_regdst, ex_alusrc, ex_aluop; data set = ex_pc_plus4, ex_read_data1, ex_read_data2, ex_sign_ext, ex_rs, ex_rt, ex_rd.
REQ-017 Normal cycle (flush=0, stall=0): every ex_* SHALL take its id_* value at the edge; ex_valid <= id_valid; latency one cycle.
REQ-018 Bubble (stall=1, flush=0): control set SHALL load 0, ex_valid <= 0, data set SHALL load id_* values (register specifiers stay meaningful for forwarding compares).
REQ-019 Flush (flush=1): control set SHALL load 0, ex_valid <= 0, data set SHALL load id_* values; flush has priority over stall.
REQ-020 ex_valid=0 SHALL always coincide with a zero control set; ex_valid=1 SHALL only follow a normal cycle with id_valid=1.
REQ-021 If id_valid=0 in a normal cycle, control set SHALL load 0 (no architectural side effect from invalid slots).
REQ-022 bubble_count SHALL increment by 1 on each edge with stall=1 and flush=0.
REQ-023 bubble_count SHALL saturate at 2^CNT_WIDTH-1, never wrap.
REQ-024 count_clr=1 SHALL load bubble_count to 0 on that edge, overriding a simultaneous increment.
REQ-025 Consecutive stall cycles SHALL each insert one bubble and count once each.
REQ-026 Block holds no state machine beyond the register; it SHALL accept new inputs every cycle without backpressure.

Reset
REQ-027 rst_n low SHALL immediately (without clk) force all ex_* outputs, ex_valid and bubble_count to 0.
REQ-028 While rst_n low, clock edges SHALL have no effect; first capture occurs at first rising edge with rst_n high.
REQ-029 Reset asserted mid-stall SHALL clear state; no bubble is counted for that edge.

Verification
REQ-030 Normal: id_valid=1, id_memread=1, id_rt=5, id_read_data1=0x12345678 -> next edge ex_memread=1, ex_rt=5, ex_read_data1=0x12345678, ex_valid=1, bubble_count unchanged.
REQ-031 Load-use: stall=1 one cycle with id_regwrite=1, id_rs=5 -> ex_regwrite=0, ex_memread=0, ex_valid=0, ex_rs=5, bubble_count 0->1.
REQ-032 Priority: stall=1 and flush=1 same edge -> control set 0, ex_valid=0, bubble_count unchanged.
REQ-033 Saturation: CNT_WIDTH=4, 20 consecutive stall cycles -> bubble_count stops at 15; then count_clr=1 with stall=1 -> bubble_count=0.
REQ-034 Async reset: after loading nonzero state, drop rst_n between clock edges -> all outputs 0 before next edge; release rst_n, hold stall=0 -> first normal capture at next edge.
